// File: rtl/memb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memb_pkg
// Description : Shared types and constants for the ASCII-binary memory loader:
//               FSM state encoding, character codes, width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package memb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CH_0  = 8'h30;  // '0'
    localparam logic [7:0] CH_1  = 8'h31;  // '1'
    localparam logic [7:0] CH_LF = 8'h0A;  // '\n'
    localparam logic [7:0] CH_CR = 8'h0D;  // '\r'
    localparam logic [7:0] CH_US = 8'h5F;  // '_'

    // $clog2 that never returns 0, so a one-entry array still gets a 1-bit address
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memb_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : memb_stream_loader_if
// Description : Byte-stream input handshake plus the array write port of the
//               loader. The loader connects as slave, its environment as master.
// Revision    : 1.0 - initial release
// ============================================================================
interface memb_stream_loader_if #(
    parameter int WA = 8,
    parameter int WB = 8
);
    import memb_pkg::*;

    localparam int AW = clog2_min1(WA);

    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;

    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [WB-1:0] m_dat;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  m_we, m_adr, m_dat
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready,
        output m_we, m_adr, m_dat
    );

endinterface
`default_nettype wire

// File: rtl/memb_line_parser.sv
`default_nettype none
// ============================================================================
// Module      : memb_line_parser
// Description : Classifies accepted ASCII bytes and accumulates binary digits
//               of the current line. Flags a completed word on a newline (or on
//               flush) when the line holds at least one digit.
// Revision    : 1.0 - initial release
// ============================================================================
module memb_line_parser
    import memb_pkg::*;
#(
    parameter int WB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,          // start of a new load
    input  logic          byte_valid,     // byte accepted this cycle
    input  logic [7:0]    byte_data,
    input  logic          flush,          // force commit of a trailing word
    output logic          word_ready,
    output logic [WB-1:0] word,
    output logic          long_err,
    output logic          char_err,
    output logic          line_open_next  // digits pending after this byte
);

    // Digit counter saturates at WB+1, enough to remember "too long"
    localparam int            DW       = clog2_min1(WB + 2);
    localparam logic [DW-1:0] DCNT_WB  = DW'(WB);
    localparam logic [DW-1:0] DCNT_MAX = DW'(WB + 1);

    logic [WB-1:0] acc;
    logic [WB-1:0] acc_next;
    logic [DW-1:0] dcnt;
    logic          is_digit;
    logic          is_lf;
    logic          is_skip;
    logic          has_digits;

    // Byte classification and word-completion decode
    always_comb begin
        is_digit       = (byte_data == CH_0) || (byte_data == CH_1);
        is_lf          = (byte_data == CH_LF);
        is_skip        = (byte_data == CH_CR) || (byte_data == CH_US);
        has_digits     = (dcnt != '0);
        // '0' and '1' differ only in bit 0; older MSBs fall off the top
        acc_next       = (acc << 1) | WB'(byte_data[0]);
        word_ready     = has_digits && ((byte_valid && is_lf) || flush);
        word           = acc;
        long_err       = byte_valid && is_digit && (dcnt >= DCNT_WB);
        char_err       = byte_valid && !(is_digit || is_lf || is_skip);
        line_open_next = is_digit || (has_digits && !is_lf);
    end

    // Accumulator and digit count; both restart at every line boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            dcnt <= '0;
        end else if (clear || word_ready) begin
            acc  <= '0;
            dcnt <= '0;
        end else if (byte_valid && is_digit) begin
            acc <= acc_next;
            if (dcnt != DCNT_MAX) begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/memb_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : memb_stream_loader
// Description : Hardware counterpart of the readmemb task: parses an ASCII
//               binary byte stream (one word per line) and writes consecutive
//               array entries from 0.
//               Reports over-long lines, excess lines and illegal characters.
// Revision    : 1.0 - initial release
// ============================================================================
module memb_stream_loader
    import memb_pkg::*;
#(
    parameter  int WA = 8,
    parameter  int WB = 8,
    localparam int AW = clog2_min1(WA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    memb_stream_loader_if.slave  bus,
    output logic                 done,
    output logic                 err_long,
    output logic                 err_over,
    output logic                 err_char,
    output logic [AW:0]          word_cnt
);

    localparam logic [AW:0] WA_CNT = (AW + 1)'(WA);

    state_t        state;
    state_t        state_nxt;
    logic          ready;
    logic          accept;
    logic          load_entry;
    logic          flush;
    logic          word_ready;
    logic [WB-1:0] word;
    logic          long_err;
    logic          char_err;
    logic          line_open_next;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [WB-1:0] dat_q;

    assign ready       = (state == LOAD);
    assign accept      = bus.s_valid && ready;
    assign bus.s_ready = ready;
    assign bus.m_we    = we_q;
    assign bus.m_adr   = adr_q;
    assign bus.m_dat   = dat_q;

    memb_line_parser #(
        .WB (WB)
    ) u_parser (
        .clk            (clk),
        .rst            (rst),
        .clear          (load_entry),
        .byte_valid     (accept),
        .byte_data      (bus.s_data),
        .flush          (flush),
        .word_ready     (word_ready),
        .word           (word),
        .long_err       (long_err),
        .char_err       (char_err),
        .line_open_next (line_open_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the final byte decides whether a trailing word needs flushing
    always_comb begin
        state_nxt  = state;
        load_entry = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                if (accept && bus.s_last) begin
                    state_nxt = line_open_next ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                flush     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write port: one registered stage after word completion; word_cnt doubles as the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            word_cnt <= '0;
            err_over <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (load_entry) begin
                word_cnt <= '0;
                err_over <= 1'b0;
            end else if (word_ready) begin
                if (word_cnt == WA_CNT) begin
                    err_over <= 1'b1;
                end else begin
                    we_q     <= 1'b1;
                    adr_q    <= word_cnt[AW-1:0];
                    dat_q    <= word;
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    // Sticky parse errors and the completion pulse, which trails the last write by a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_long <= 1'b0;
            err_char <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (load_entry) begin
                err_long <= 1'b0;
                err_char <= 1'b0;
            end else begin
                if (long_err) begin
                    err_long <= 1'b1;
                end
                if (char_err) begin
                    err_char <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memb_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_memb_stream_loader
// Description : Directed self-checking bench for memb_stream_loader (WA=8, WB=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memb_stream_loader;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          done;
    logic          err_long;
    logic          err_over;
    logic          err_char;
    logic [AW:0]   word_cnt;

    int checks   = 0;
    int failures = 0;

    memb_stream_loader_if #(.WA(WA), .WB(WB)) bus ();

    memb_stream_loader #(
        .WA (WA),
        .WB (WB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.slave),
        .done     (done),
        .err_long (err_long),
        .err_over (err_over),
        .err_char (err_char),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter and write/done monitor, sampled on the falling edge
    int cyc = 0;
    int wr_adr[$];
    int wr_dat[$];
    int wr_rdy_before[$];
    int last_wr_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.m_we) begin
            wr_adr.push_back(int'(bus.m_adr));
            wr_dat.push_back(int'(bus.m_dat));
            wr_rdy_before.push_back(int'(prev_ready));
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_ready = bus.s_ready;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send_byte(input logic [7:0] b, input logic last, input bit gap);
        int waited;
        waited = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        bus.s_last  = last;
        while (!bus.s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", bus.s_ready, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input bit last, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last && (i == s.len() - 1), gap);
        end
    endtask

    function automatic string bin_line(input int v, input int nd);
        string s;
        s = "";
        for (int i = nd - 1; i >= 0; i--) begin
            s = {s, (((v >> i) & 1) != 0) ? "1" : "0"};
        end
        return {s, "\n"};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - base, 1);
    endtask

    initial begin : main
        string s;
        int    bw;
        int    bd;

        rst         = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_adr", bus.m_adr, 0);
        check("rst_m_dat", bus.m_dat, 0);
        check("rst_done", done, 0);
        check("rst_errs", {err_long, err_over, err_char}, 0);
        check("rst_word_cnt", word_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_s_ready", bus.s_ready, 0);

        // 1: eight full-width lines 0..7
        bw = wr_adr.size();
        bd = done_cnt;
        s  = "";
        for (int v = 0; v < 8; v++) s = {s, bin_line(v, 8)};
        pulse_start();
        send_str(s, 1'b1, 1'b0);
        wait_done("t1", bd);
        check("t1_nwr", wr_adr.size() - bw, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1_adr%0d", k), wr_adr[bw + k], k);
            check($sformatf("t1_dat%0d", k), wr_dat[bw + k], k);
        end
        check("t1_word_cnt", word_cnt, 8);
        check("t1_errs", {err_long, err_over, err_char}, 0);
        check("t1_done_gap", done_cyc - last_wr_cyc, 1);

        // 2: nine lines, the ninth overflows
        bw = wr_adr.size();
        bd = done_cnt;
        s  = "";
        for (int v = 0; v < 9; v++) s = {s, bin_line(v, 8)};
        pulse_start();
        send_str(s, 1'b1, 1'b0);
        wait_done("t2", bd);
        check("t2_nwr", wr_adr.size() - bw, 8);
        check("t2_adr7", wr_adr[bw + 7], 7);
        check("t2_dat7", wr_dat[bw + 7], 7);
        check("t2_word_cnt", word_cnt, 8);
        check("t2_err_over", err_over, 1);
        check("t2_err_long", err_long, 0);

        // 3: short line zero-extends, long line keeps its low digits
        bw = wr_adr.size();
        bd = done_cnt;
        pulse_start();
        send_str("0000011\n100000101\n", 1'b1, 1'b0);
        wait_done("t3", bd);
        check("t3_nwr", wr_adr.size() - bw, 2);
        check("t3_dat0", wr_dat[bw], 8'h03);
        check("t3_adr1", wr_adr[bw + 1], 1);
        check("t3_dat1", wr_dat[bw + 1], 8'h05);
        check("t3_err_long", err_long, 1);
        check("t3_err_over", err_over, 0);
        check("t3_word_cnt", word_cnt, 2);

        // 4: separators, empty line, trailing word without newline, gapped valid
        bw = wr_adr.size();
        bd = done_cnt;
        pulse_start();
        send_str("1_01\r\n\n10", 1'b1, 1'b1);
        wait_done("t4", bd);
        check("t4_nwr", wr_adr.size() - bw, 2);
        check("t4_adr0", wr_adr[bw], 0);
        check("t4_dat0", wr_dat[bw], 8'h05);
        check("t4_adr1", wr_adr[bw + 1], 1);
        check("t4_dat1", wr_dat[bw + 1], 8'h02);
        check("t4_flush_not_ready", wr_rdy_before[bw + 1], 0);
        check("t4_errs", {err_long, err_over, err_char}, 0);
        check("t4_word_cnt", word_cnt, 2);
        check("t4_done_gap", done_cyc - last_wr_cyc, 1);

        // 5: illegal character, then asynchronous reset mid-stream
        pulse_start();
        send_str("0101\nx0", 1'b0, 1'b0);
        check("t5_err_char", err_char, 1);
        check("t5_word_cnt_pre", word_cnt, 1);
        check("t5_m_dat_pre", bus.m_dat, 8'h05);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_s_ready", bus.s_ready, 0);
        check("t5_rst_m_dat", bus.m_dat, 0);
        check("t5_rst_errs", {err_long, err_over, err_char}, 0);
        check("t5_rst_word_cnt", word_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bw = wr_adr.size();
        bd = done_cnt;
        pulse_start();
        send_str("11\n", 1'b1, 1'b0);
        wait_done("t5", bd);
        check("t5_nwr", wr_adr.size() - bw, 1);
        check("t5_adr0", wr_adr[bw], 0);
        check("t5_dat0", wr_dat[bw], 8'h03);
        check("t5_word_cnt", word_cnt, 1);
        check("t5_err_char_post", err_char, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
